// File: rtl/counter_xdown_pkg.sv
// Shared types and constants for the down-counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam int CNT_RST_VAL = 0;

endpackage

// File: rtl/counter_xdown_if.sv
// Control/status bundle of counter_xdown: master drives the controls, slave is the counter.
interface counter_xdown_if #(
    parameter int NUM_CNT_BITS = 4
);
    import counter_pkg::*;

    logic                    load;
    logic [NUM_CNT_BITS-1:0] start_val;
    logic [NUM_CNT_BITS-1:0] floor_val;
    logic                    count_enable;
    logic                    sync_reset;
    logic [NUM_CNT_BITS-1:0] value;
    logic                    underflow_flag;
    logic                    done_pulse;
    logic                    busy;
    // Observation points for checkers: FSM state and captured reload value.
    cnt_state_t              dbg_state;
    logic [NUM_CNT_BITS-1:0] dbg_reload;

    modport master (
        output load, start_val, floor_val, count_enable, sync_reset,
        input  value, underflow_flag, done_pulse, busy, dbg_state, dbg_reload
    );

    modport slave (
        input  load, start_val, floor_val, count_enable, sync_reset,
        output value, underflow_flag, done_pulse, busy, dbg_state, dbg_reload
    );

endinterface

// File: rtl/counter_xdown.sv
// Loadable down-counter to a programmable floor with registered terminal flag.
// COUNTER_XDOWN_AUTORELOAD_EN selects periodic reload instead of one-shot termination.
module counter_xdown
    import counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    counter_xdown_if.slave    bus
);

    cnt_state_t              r_state;
    cnt_state_t              w_next_state;
    logic [NUM_CNT_BITS-1:0] r_value;
    logic [NUM_CNT_BITS-1:0] r_reload;
    logic                    r_underflow;
    logic                    r_done_pulse;
    logic                    w_dec_req;
    logic                    w_terminal;

    // Less-or-equal rather than equality stops a start below the floor from wrapping.
    assign w_dec_req  = (r_state == RUN) && bus.count_enable;
    assign w_terminal = (r_value <= bus.floor_val);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.sync_reset) begin
            w_next_state = IDLE;
        end else if (bus.load) begin
            w_next_state = RUN;
        end else if (w_dec_req && w_terminal) begin
`ifdef COUNTER_XDOWN_AUTORELOAD_EN
            w_next_state = RUN;
`else
            w_next_state = DONE;
`endif
        end
    end

    always_comb begin
        bus.busy       = (r_state == RUN);
        bus.dbg_state  = r_state;
        bus.dbg_reload = r_reload;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_value      <= NUM_CNT_BITS'(CNT_RST_VAL);
            r_reload     <= NUM_CNT_BITS'(CNT_RST_VAL);
            r_underflow  <= 1'b0;
            r_done_pulse <= 1'b0;
        end else if (bus.sync_reset) begin
            r_value      <= NUM_CNT_BITS'(CNT_RST_VAL);
            r_underflow  <= 1'b0;
            r_done_pulse <= 1'b0;
        end else if (bus.load) begin
            r_value      <= bus.start_val;
            r_reload     <= bus.start_val;
            r_underflow  <= 1'b0;
            r_done_pulse <= 1'b0;
        end else if (w_dec_req) begin
            if (w_terminal) begin
                r_underflow  <= 1'b1;
                r_done_pulse <= 1'b1;
`ifdef COUNTER_XDOWN_AUTORELOAD_EN
                r_value      <= r_reload;
`else
                r_value      <= bus.floor_val;
`endif
            end else begin
                r_value      <= r_value - 1'b1;
                r_underflow  <= 1'b0;
                r_done_pulse <= 1'b0;
            end
        end else begin
            r_done_pulse <= 1'b0;
        end
    end

    assign bus.value          = r_value;
    assign bus.underflow_flag = r_underflow;
    assign bus.done_pulse     = r_done_pulse;

endmodule

// File: tb/tb_counter_xdown.sv
// Directed and random checks of counter_xdown against a rule-level reference model.
module tb_counter_xdown;

    localparam int W = 4;
`ifdef COUNTER_XDOWN_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk;
    logic n_rst;
    int   checks;
    int   failures;

    counter_xdown_if #(.NUM_CNT_BITS(W)) bus ();

    counter_xdown #(.NUM_CNT_BITS(W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining count, flags, and whether the counter is armed/finished.
    int m_val;
    int m_reload;
    bit m_flag;
    bit m_pulse;
    bit m_armed;

    function automatic void model_step(bit rst_n, bit ld, int sv, int fv, bit ce, bit sr);
        if (!rst_n) begin
            m_val = 0; m_reload = 0; m_flag = 0; m_pulse = 0; m_armed = 0;
        end else if (sr) begin
            m_val = 0; m_flag = 0; m_pulse = 0; m_armed = 0;
        end else if (ld) begin
            m_val = sv; m_reload = sv; m_flag = 0; m_pulse = 0; m_armed = 1;
        end else if (m_armed && ce) begin
            if (m_val <= fv) begin
                m_flag  = 1;
                m_pulse = 1;
                if (AUTO) begin
                    m_val = m_reload;
                end else begin
                    m_val   = fv;
                    m_armed = 0;
                end
            end else begin
                m_val   = m_val - 1;
                m_flag  = 0;
                m_pulse = 0;
            end
        end else begin
            m_pulse = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        checks++;
        assert (bus.value === W'(m_val)) else begin
            failures++;
            $error("FAIL %s value: got %0d expected %0d", tag, bus.value, m_val);
        end
        checks++;
        assert (bus.underflow_flag === m_flag) else begin
            failures++;
            $error("FAIL %s underflow_flag: got %0b expected %0b", tag, bus.underflow_flag, m_flag);
        end
        checks++;
        assert (bus.done_pulse === m_pulse) else begin
            failures++;
            $error("FAIL %s done_pulse: got %0b expected %0b", tag, bus.done_pulse, m_pulse);
        end
        checks++;
        assert (bus.busy === m_armed) else begin
            failures++;
            $error("FAIL %s busy: got %0b expected %0b", tag, bus.busy, m_armed);
        end
    endtask

    // One clock: apply inputs, advance the model, sample 1ns after the edge.
    task automatic step(input bit rst_n, input bit ld, input int sv, input int fv,
                        input bit ce, input bit sr, input string tag);
        n_rst            = rst_n;
        bus.load         = ld;
        bus.start_val    = W'(sv);
        bus.floor_val    = W'(fv);
        bus.count_enable = ce;
        bus.sync_reset   = sr;
        @(posedge clk);
        model_step(rst_n, ld, sv, fv, ce, sr);
        #1;
        check_all(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_val = 0; m_reload = 0; m_flag = 0; m_pulse = 0; m_armed = 0;

        // Reset held with load asserted
        step(1'b0, 1'b1, 9, 2, 1'b0, 1'b0, "reset0");
        step(1'b0, 1'b1, 9, 2, 1'b0, 1'b0, "reset1");
        checks++;
        assert (bus.value === 4'd0 && bus.busy === 1'b0) else begin
            failures++;
            $error("FAIL reset_const: got value=%0d busy=%0b expected 0/0", bus.value, bus.busy);
        end

        // IDLE ignores count_enable
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, "idle_ce");

        // Basic countdown 9 -> 2, terminal, then post-terminal behaviour
        step(1'b1, 1'b1, 9, 2, 1'b0, 1'b0, "load9");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, 2, 1'b1, 1'b0, "countdown");
        checks++;
        assert (bus.underflow_flag === (AUTO ? 1'b0 : 1'b1)) else begin
            failures++;
            $error("FAIL post_term_flag: got %0b expected %0b", bus.underflow_flag, !AUTO);
        end

        // Enable gaps: 5,4,4,4,3
        step(1'b1, 1'b1, 5, 0, 1'b0, 1'b0, "gap_load");
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, "gap1");
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, "gap2");
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, "gap3");
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, "gap4");
        checks++;
        assert (bus.value === 4'd3) else begin
            failures++;
            $error("FAIL gap_const: got %0d expected 3", bus.value);
        end

        // Load mid-count wins over count_enable
        step(1'b1, 1'b1, 9, 0, 1'b0, 1'b0, "mid_load9");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, "mid_dec");
        step(1'b1, 1'b1, 12, 0, 1'b1, 1'b0, "mid_load12");
        checks++;
        assert (bus.value === 4'd12) else begin
            failures++;
            $error("FAIL mid_load_const: got %0d expected 12", bus.value);
        end

        // sync_reset beats load; enable afterwards has no effect
        step(1'b1, 1'b1, 7, 0, 1'b1, 1'b1, "sr_load");
        step(1'b1, 1'b0, 7, 0, 1'b1, 1'b0, "sr_idle1");
        step(1'b1, 1'b0, 7, 0, 1'b1, 1'b0, "sr_idle2");

        // start below floor: first enable is terminal, no wrap
        step(1'b1, 1'b1, 1, 5, 1'b0, 1'b0, "lt_load");
        step(1'b1, 1'b0, 0, 5, 1'b1, 1'b0, "lt_term");
        checks++;
        assert (bus.done_pulse === 1'b1 && bus.value === (AUTO ? 4'd1 : 4'd5)) else begin
            failures++;
            $error("FAIL lt_const: got value=%0d pulse=%0b expected %0d/1",
                   bus.value, bus.done_pulse, AUTO ? 1 : 5);
        end
        step(1'b1, 1'b0, 0, 5, 1'b1, 1'b0, "lt_after");

        // start equal to floor
        step(1'b1, 1'b1, 3, 3, 1'b0, 1'b0, "eq_load");
        step(1'b1, 1'b0, 0, 3, 1'b1, 1'b0, "eq_term");

        // Randomized traffic with changing floor
        begin
            int fv;
            fv = 0;
            for (int i = 0; i < 400; i++) begin
                bit rst_n, ld, ce, sr;
                if ($urandom_range(0, 15) == 0) fv = $urandom_range(0, 6);
                rst_n = ($urandom_range(0, 99) != 0);
                sr    = ($urandom_range(0, 39) == 0);
                ld    = ($urandom_range(0, 9) == 0);
                ce    = ($urandom_range(0, 3) != 0);
                step(rst_n, ld, $urandom_range(0, 15), fv, ce, sr, "random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
